// File: rtl/laser_pkg.sv
// laser_pkg: shared types and constants for the LASER coverage search.
//   state_t       - sequencer states
//   GRID_W/CNT_W/SQ_W - coordinate, count and squared-distance widths
//   NPTS_DEF/RADIUS_SQ_DEF - default frame size and inclusive radius^2
package laser_pkg;
    localparam int GRID_W        = 4;
    localparam int CNT_W         = 6;
    localparam int SQ_W          = 9;
    localparam int NPTS_DEF      = 40;
    localparam int RADIUS_SQ_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_FIN
    } state_t;
endpackage

// File: rtl/laser_hit.sv
// laser_hit: combinational coverage test of one point against one centre.
//   i_px/i_py - point coordinates (unsigned)
//   i_cx/i_cy - candidate centre coordinates (unsigned)
//   o_hit     - 1 when (px-cx)^2 + (py-cy)^2 <= RADIUS_SQ
// All signed arithmetic of the datapath lives here.
module laser_hit
    import laser_pkg::*;
#(
    parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
    input  logic [GRID_W-1:0] i_px,
    input  logic [GRID_W-1:0] i_py,
    input  logic [GRID_W-1:0] i_cx,
    input  logic [GRID_W-1:0] i_cy,
    output logic              o_hit
);
    // Product width: a 5-bit signed square needs at most 9 magnitude bits.
    localparam int PW = 2 * (GRID_W + 1);
    localparam logic [SQ_W-1:0] RSQ = SQ_W'(RADIUS_SQ);

    logic signed [GRID_W:0] w_dx;
    logic signed [GRID_W:0] w_dy;
    logic signed [PW-1:0]   w_dx2;
    logic signed [PW-1:0]   w_dy2;
    logic [SQ_W-1:0]        w_sq;

    // Zero-extend both operands so the difference is a true signed delta.
    assign w_dx  = $signed({1'b0, i_px}) - $signed({1'b0, i_cx});
    assign w_dy  = $signed({1'b0, i_py}) - $signed({1'b0, i_cy});
    // Sign-extend before multiplying so negative deltas square correctly.
    assign w_dx2 = PW'(w_dx) * PW'(w_dx);
    assign w_dy2 = PW'(w_dy) * PW'(w_dy);
    // Each square is <= 225, so the 9-bit sum (<= 450) cannot overflow.
    assign w_sq  = SQ_W'($unsigned(w_dx2)) + SQ_W'($unsigned(w_dy2));
    assign o_hit = (w_sq <= RSQ);
endmodule

// File: rtl/laser_scan_ctrl.sv
// laser_scan_ctrl: loads a frame of NPTS points, then scans all 256 grid
// centres in raster order (cx fastest), one point per cycle, and reports the
// first centre with maximum coverage.
//   i_clk, i_rst_n       - clock, async active-low reset
//   i_in_valid, i_x, i_y - point input (ignored while scanning / finishing)
//   o_busy               - high during the scan
//   o_done               - one-cycle pulse, result valid
//   o_cx, o_cy, o_cnt    - best centre and its coverage count
module laser_scan_ctrl
    import laser_pkg::*;
#(
    parameter int NPTS      = NPTS_DEF,
    parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    input  logic [GRID_W-1:0] i_x,
    input  logic [GRID_W-1:0] i_y,
    output logic              o_busy,
    output logic              o_done,
    output logic [GRID_W-1:0] o_cx,
    output logic [GRID_W-1:0] o_cy,
    output logic [CNT_W-1:0]  o_cnt
);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(NPTS - 1);

    state_t                  r_state;
    logic [2*GRID_W-1:0]     r_pts [NPTS];
    logic [CNT_W-1:0]        r_ld;
    logic [CNT_W-1:0]        r_p;
    logic [2*GRID_W-1:0]     r_cidx;
    logic [CNT_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_best;

    logic                    w_store_en;
    logic [CNT_W-1:0]        w_store_idx;
    logic [2*GRID_W-1:0]     w_pt;
    logic                    w_hit;
    logic [CNT_W-1:0]        w_total;

    assign w_store_en  = i_in_valid && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_store_idx = (r_state == S_IDLE) ? '0 : r_ld;
    assign w_pt        = r_pts[r_p];
    // acc never exceeds NPTS-1 before the last point, so total fits CNT_W.
    assign w_total     = r_acc + {{(CNT_W-1){1'b0}}, w_hit};

    laser_hit #(.RADIUS_SQ(RADIUS_SQ)) u_hit (
        .i_px  (w_pt[GRID_W-1:0]),
        .i_py  (w_pt[2*GRID_W-1:GRID_W]),
        .i_cx  (r_cidx[GRID_W-1:0]),
        .i_cy  (r_cidx[2*GRID_W-1:GRID_W]),
        .o_hit (w_hit)
    );

    // Point store needs no reset: a new frame always overwrites every entry
    // before the scan reads it.
    always_ff @(posedge i_clk) begin
        if (w_store_en) r_pts[w_store_idx] <= {i_y, i_x};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ld    <= '0;
            r_p     <= '0;
            r_cidx  <= '0;
            r_acc   <= '0;
            r_best  <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_cx    <= '0;
            o_cy    <= '0;
            o_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    o_done <= 1'b0;
                    if (i_in_valid) begin
                        if (w_store_idx == P_LAST) begin
                            r_state <= S_SCAN;
                            o_busy  <= 1'b1;
                            r_ld    <= '0;
                            r_p     <= '0;
                            r_cidx  <= '0;
                            r_acc   <= '0;
                            r_best  <= '0;
                        end else begin
                            r_state <= S_LOAD;
                            r_ld    <= w_store_idx + 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_p == P_LAST) begin
                        r_p   <= '0;
                        r_acc <= '0;
                        // Strict compare keeps the earliest raster centre on ties.
                        if (w_total > r_best) begin
                            r_best <= w_total;
                            o_cnt  <= w_total;
                            o_cx   <= r_cidx[GRID_W-1:0];
                            o_cy   <= r_cidx[2*GRID_W-1:GRID_W];
                        end
                        if (r_cidx == '1) begin
                            r_state <= S_FIN;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            r_cidx <= r_cidx + 1'b1;
                        end
                    end else begin
                        r_p   <= r_p + 1'b1;
                        r_acc <= w_total;
                    end
                end
                S_FIN: begin
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Bench for laser_scan_ctrl: directed frames, a spec-level coverage model and
// a per-cycle compare of BUSY/DONE/result against it, plus literal checks.
module tb_laser_scan_ctrl;
    localparam int NPTS     = 40;
    localparam int RSQ      = 16;
    localparam int SCAN_CYC = 256 * NPTS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] x, y;
    logic       busy, done;
    logic [3:0] cx, cy;
    logic [5:0] cnt;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    bit [7:0] fr [NPTS];

    // model state
    int m_k = -1;          // cycle label since last accepted point, -1 = not running
    int m_nld = 0;
    int m_px [64];
    int m_py [64];
    int m_ex, m_ey, m_ec;  // expected result of the frame being scanned
    int m_rx = 0, m_ry = 0, m_rc = 0;  // last reported result

    laser_scan_ctrl #(.NPTS(NPTS), .RADIUS_SQ(RSQ)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_in_valid (in_valid),
        .i_x        (x),
        .i_y        (y),
        .o_busy     (busy),
        .o_done     (done),
        .o_cx       (cx),
        .o_cy       (cy),
        .o_cnt      (cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Brute-force coverage search straight from the definition.
    function automatic void model_best(output int bx, output int by, output int bc);
        bx = 0; by = 0; bc = 0;
        for (int ccy = 0; ccy < 16; ccy++)
            for (int ccx = 0; ccx < 16; ccx++) begin
                int c = 0;
                for (int p = 0; p < NPTS; p++) begin
                    int dx = m_px[p] - ccx;
                    int dy = m_py[p] - ccy;
                    if (dx * dx + dy * dy <= RSQ) c++;
                end
                if (c > bc) begin bc = c; bx = ccx; by = ccy; end
            end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = -1; m_nld = 0; m_rx = 0; m_ry = 0; m_rc = 0;
        end else if (m_k >= 0) begin
            m_k++;
            if (m_k == SCAN_CYC + 1) begin m_rx = m_ex; m_ry = m_ey; m_rc = m_ec; end
            if (m_k > SCAN_CYC + 1) m_k = -1;
        end else if (in_valid) begin
            m_px[m_nld] = int'(x);
            m_py[m_nld] = int'(y);
            m_nld++;
            if (m_nld == NPTS) begin
                model_best(m_ex, m_ey, m_ec);
                m_nld = 0;
                m_k = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_k >= 1 && m_k <= SCAN_CYC));
        chk("done", int'(done), int'(m_k == SCAN_CYC + 1));
        if (!(m_k >= 1 && m_k <= SCAN_CYC)) begin
            chk("cx", int'(cx), m_rx);
            chk("cy", int'(cy), m_ry);
            chk("cnt", int'(cnt), m_rc);
        end
    end

    task automatic send_frame();
        for (int i = 0; i < NPTS; i++) begin
            in_valid = 1'b1;
            x = fr[i][3:0];
            y = fr[i][7:4];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    // Returns in the cycle after DONE so a following frame loads immediately.
    task automatic wait_done(input bit tog, output int lat, output int rx,
                             output int ry, output int rc);
        int n = 0;
        bit got = 0;
        lat = 0; rx = 0; ry = 0; rc = 0;
        while (!got && n < SCAN_CYC + 500) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1;
                lat = cyc - acc_cyc + 1;
                rx = int'(cx); ry = int'(cy); rc = int'(cnt);
            end else if (tog) begin
                in_valid = 1'($urandom_range(0, 1));
                x = 4'($urandom_range(0, 15));
                y = 4'($urandom_range(0, 15));
            end
        end
        in_valid = 1'b0;
        if (!got) begin
            n_checks++; n_errs++;
            $display("FAIL done_timeout: no DONE after %0d cycles", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input string nm, input bit tog, input int ex,
                             input int ey, input int ec);
        int lat, rx, ry, rc;
        send_frame();
        wait_done(tog, lat, rx, ry, rc);
        chk({nm, "_lat"}, lat, SCAN_CYC + 1);
        chk({nm, "_cx"}, rx, ex);
        chk({nm, "_cy"}, ry, ey);
        chk({nm, "_cnt"}, rc, ec);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // all at origin, random IN_VALID noise during the scan
        for (int i = 0; i < NPTS; i++) fr[i] = 8'h00;
        run_frame("origin", 1'b1, 0, 0, 40);
        // back-to-back frames: corner, then two clusters
        for (int i = 0; i < NPTS; i++) fr[i] = 8'hFF;
        run_frame("corner", 1'b0, 15, 11, 40);
        for (int i = 0; i < NPTS; i++) fr[i] = (i < 20) ? 8'h33 : 8'hCC;
        run_frame("tie", 1'b0, 1, 0, 20);
        repeat (3) @(posedge clk);
        #1;
        // inclusive radius: (8,12) sits exactly at sq=16 from (8,8)
        for (int i = 0; i < NPTS; i++) fr[i] = (i < 39) ? 8'h88 : 8'hC8;
        run_frame("edge", 1'b0, 8, 8, 40);

        // reset mid-scan, then a fresh frame
        for (int i = 0; i < NPTS; i++) fr[i] = 8'h00;
        send_frame();
        repeat (4999) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cnt", int'(cnt), 0);
        chk("mid_rst_cx", int'(cx), 0);
        chk("mid_rst_cy", int'(cy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("after_rst", 1'b0, 0, 0, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/laser_scan_ctrl.md
# laser_scan_ctrl

Sequencer for the LASER coverage search. It captures a frame of NPTS target points on the 16×16 grid. It then scans every candidate centre in raster order and counts, one point per cycle, how many points lie within RADIUS_SQ of that centre. It reports the first centre with maximum coverage. It owns the signed distance datapath and its width rules, and sits between the point-input interface and the downstream result consumer.

## Interface
- NPTS, 40, points per frame (1..63)
- RADIUS_SQ, 16, inclusive squared-radius threshold (unsigned, ≤ 450)
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- IN_VALID  in  1  X/Y carry a point this cycle
- X  in  4  point x coordinate, unsigned 0..15
- Y  in  4  point y coordinate, unsigned 0..15
- BUSY  out  1  high while scanning; input is ignored
- DONE  out  1  one-cycle pulse; result valid
- CX  out  4  best centre x
- CY  out  4  best centre y
- CNT  out  6  points covered by the best centre

## Operation
- States: IDLE, LOAD, SCAN, FIN.
- IDLE: when IN_VALID=1, store point 0, load counter = 1, go to LOAD.
- LOAD: each IN_VALID=1 cycle stores the next point. After point NPTS-1 is stored, go to SCAN. Cycles with IN_VALID=0 stall.
- SCAN: the centre index is {cy,cx}, with cx fastest, running 0..255. The point index p runs 0..NPTS-1 per centre.
  - Each cycle: acc += hit(p). Clear acc when p wraps.
  - When p=NPTS-1: total = acc + hit. If total > best_cnt (strictly greater), set best = (cx, cy, total). Ties keep the earlier raster centre.
- FIN: pulse DONE, then go to IDLE. CX/CY/CNT hold until the next frame's SCAN updates them.
- At the start of SCAN, best_cnt = 0 and best centre = (0,0). A frame with zero coverage everywhere cannot occur, because each point covers its own centre.
- hit arithmetic:
  - dx = {1'b0,px} − {1'b0,cx}, computed as 5-bit signed; dy likewise.
  - sq = dx·dx + dy·dy, computed as 9-bit unsigned (maximum 450).
  - hit = (sq ≤ RADIUS_SQ).
  - Both operands are zero-extended to signed before subtracting. No unsized or 1-bit literals are mixed into signed expressions, and no comparison against 0 is made on a mixed-signedness expression.
- IN_VALID during SCAN or FIN is ignored and the sample is dropped.

## Timing
- Reset values: BUSY=0, DONE=0, CX=0, CY=0, CNT=0. The FSM goes to IDLE and the load counter clears.
- If the last point is accepted at edge t, then:
  - SCAN occupies cycles t+1 .. t+256·NPTS, which is 10240 cycles for the default NPTS.
  - DONE is high for the single cycle after that, t+256·NPTS+1.
- BUSY is high for exactly the SCAN cycles.
- CX/CY/CNT may change only at the final-point cycle of a centre. They are stable and correct when DONE is high.
- A new frame may start on the cycle after DONE.
- Reset asserted mid-LOAD or mid-SCAN aborts the frame immediately. All outputs return to reset values and the partial frame is discarded.

## Structure
- Shared package laser_pkg holds:
  - the state enum;
  - GRID_W=4, CNT_W=6, SQ_W=9;
  - the NPTS and RADIUS_SQ defaults.
- Sub-module laser_hit: purely combinational. Inputs px, py, cx, cy; output hit. It contains all signed-width logic so the rules above are verified in one place.
- The point store is a register array of NPTS × 8 bits inside laser_scan_ctrl.

## Test plan
- All 40 points at (0,0) → CNT=40, CX=0, CY=0. DONE arrives exactly 10241 cycles after the last point is accepted.
- All 40 points at (15,15) → CNT=40, CX=15, CY=11. This checks the signed negative dy and the first-in-raster tie rule.
- 20 points at (3,3) and 20 at (12,12) → CNT=20, CX=1, CY=0. The earlier cluster wins the tie.
- 39 points at (8,8) and 1 at (8,12) → CNT=40, CX=8, CY=8. This checks the inclusive bound sq=16.
- RST low during SCAN (cycle 5000), then a fresh frame of 40 points at (0,0) → outputs are 0 during reset, and the new run reports CNT=40.
- IN_VALID toggling with random X/Y during SCAN, followed by two back-to-back frames → results are unaffected. The second frame loads starting the cycle after DONE.
